// File: rtl/cs_health_monitor_if.sv
// Observation bus between the coherent sampler tap and the health monitor.
// Carries the sampler req/cnt, the clear request and all health-test results.
// The monitor only listens to CSReq/CSCnt; it never drives the sampler's ack.
interface cs_health_monitor_if #(
  parameter int CSCntWidth = 16
);
  logic                  CSReq;
  logic [CSCntWidth-1:0] CSCnt;
  logic                  clearFail;
  logic                  bitOut;
  logic                  bitValid;
  logic                  gatedValid;
  logic                  rctFail;
  logic                  aptFail;
  logic                  healthy;

  // Stimulus side: drives the sampler view and the clear request.
  modport master (
    output CSReq, CSCnt, clearFail,
    input  bitOut, bitValid, gatedValid, rctFail, aptFail, healthy
  );

  // Monitor side.
  modport slave (
    input  CSReq, CSCnt, clearFail,
    output bitOut, bitValid, gatedValid, rctFail, aptFail, healthy
  );
endinterface

// File: rtl/cs_health_monitor.sv
// Online RCT/APT health tests on the raw bit (CSCnt[0]) of each coherent-sampler sample.
// Latency: CSReq rise -> bitValid in 3-4 clk; flags/healthy update on the bitValid edge.
// No backpressure: passive observer of the sampler handshake; gatedValid qualifies bits.
module cs_health_monitor #(
  parameter int CSCntWidth   = 16,
  parameter int RCTCutoff    = 32,
  parameter int APTWindowLog = 10,
  parameter int APTCutoff    = 600
) (
  input logic                clk,
  input logic                rst,
  cs_health_monitor_if.slave bus
);

  localparam int              AW     = APTWindowLog + 1;
  localparam logic [7:0]      RctCut = 8'(RCTCutoff);
  localparam logic [AW-1:0]   AptCut = AW'(APTCutoff);
  localparam logic [AW-1:0]   WinLen = AW'(1 << APTWindowLog);
  localparam logic [AW-1:0]   AptOne = AW'(1);

  typedef enum logic {APT_IDLE, APT_WINDOW} apt_state_e;

  // Only bit 0 of the count carries entropy; the rest is observed but ignored.
  logic [CSCntWidth-1:0] cnt_w;
  logic                  unused_cnt;
  assign cnt_w      = bus.CSCnt;
  assign unused_cnt = ^cnt_w;

  logic req_meta_q, req_s_q, req_d_q;
  logic ev;
  logic bit_q, valid_q;

  logic       last_q, rct_q;
  logic [7:0] run_q;

  apt_state_e        apt_state_q;
  logic              ref_q, winfail_q, apt_q, startup_q, healthy_q;
  logic [AW-1:0]     match_q, win_q;

  logic [7:0]    run_d;
  logic          rct_set, apt_set, win_done;
  logic          ref_d, winfail_base, winfail_d;
  logic [AW-1:0] match_d, win_d;
  logic          rct_d, apt_d, startup_d;

  // Two-flop synchroniser for the RO-domain request plus a delay flop for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_meta_q <= 1'b0;
      req_s_q    <= 1'b0;
      req_d_q    <= 1'b0;
    end else begin
      req_meta_q <= bus.CSReq;
      req_s_q    <= req_meta_q;
      req_d_q    <= req_s_q;
    end
  end

  // One event per req rise, however long req stays high.
  assign ev = req_s_q & ~req_d_q;

  // Capture the raw bit on the event; cnt is held by the sampler until ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= ev;
      if (ev) bit_q <= cnt_w[0];
    end
  end

  // Candidate next values of the test state if the current bit is counted.
  always_comb begin
    run_d = 8'd1;
    if (run_q != 8'd0 && bit_q == last_q) begin
      run_d = (run_q == RctCut) ? RctCut : run_q + 8'd1;
    end
    rct_set = (run_d == RctCut);

    if (apt_state_q == APT_IDLE) begin
      ref_d        = bit_q;
      match_d      = AptOne;
      win_d        = AptOne;
      winfail_base = 1'b0;
    end else begin
      ref_d        = ref_q;
      win_d        = win_q + AptOne;
      match_d      = (bit_q == ref_q) ? match_q + AptOne : match_q;
      winfail_base = winfail_q;
    end
    apt_set   = (match_d == AptCut);
    win_done  = (win_d == WinLen);
    winfail_d = winfail_base | apt_set;

    rct_d     = rct_q | rct_set;
    apt_d     = apt_q | apt_set;
    startup_d = startup_q | (win_done & ~winfail_d);
  end

  // Repetition count test: run length of identical bits, sticky failure at the cutoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b0;
      run_q  <= 8'd0;
      rct_q  <= 1'b0;
    end else if (bus.clearFail) begin
      last_q <= 1'b0;
      run_q  <= 8'd0;
      rct_q  <= 1'b0;
    end else if (valid_q) begin
      last_q <= bit_q;
      run_q  <= run_d;
      rct_q  <= rct_d;
    end
  end

  // Adaptive proportion test FSM: back-to-back windows, startup passes on a clean window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      apt_state_q <= APT_IDLE;
      ref_q       <= 1'b0;
      match_q     <= '0;
      win_q       <= '0;
      winfail_q   <= 1'b0;
      apt_q       <= 1'b0;
      startup_q   <= 1'b0;
    end else if (bus.clearFail) begin
      apt_state_q <= APT_IDLE;
      ref_q       <= 1'b0;
      match_q     <= '0;
      win_q       <= '0;
      winfail_q   <= 1'b0;
      apt_q       <= 1'b0;
      startup_q   <= 1'b0;
    end else if (valid_q) begin
      ref_q       <= ref_d;
      match_q     <= match_d;
      win_q       <= win_d;
      winfail_q   <= winfail_d;
      apt_q       <= apt_d;
      startup_q   <= startup_d;
      apt_state_q <= win_done ? APT_IDLE : APT_WINDOW;
    end
  end

  // Health summary, registered alongside the flags it is derived from.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      healthy_q <= 1'b0;
    end else if (bus.clearFail) begin
      healthy_q <= 1'b0;
    end else if (valid_q) begin
      healthy_q <= startup_d & ~rct_d & ~apt_d;
    end
  end

  assign bus.bitOut     = bit_q;
  assign bus.bitValid   = valid_q;
  // Uses the pre-update health, so the failing sample is judged by the old state.
  assign bus.gatedValid = valid_q & healthy_q;
  assign bus.rctFail    = rct_q;
  assign bus.aptFail    = apt_q;
  assign bus.healthy    = healthy_q;

endmodule

// File: tb/tb_cs_health_monitor.sv
// Bench for cs_health_monitor: scoreboard of per-sample expectations plus
// segment tables and directed sequences for startup, RCT, APT, clear and reset.
module tb_cs_health_monitor;

  logic clk;
  logic rst;

  cs_health_monitor_if #(.CSCntWidth(16)) bus ();

  cs_health_monitor #(
    .CSCntWidth(16), .RCTCutoff(32), .APTWindowLog(10), .APTCutoff(600)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference of the health tests ----------------
  typedef struct packed {
    logic b;
    logic gated;
    logic rct;
    logic apt;
    logic hlt;
  } exp_t;

  logic m_first, m_last, m_inwin, m_ref, m_wfail;
  logic m_rct, m_apt, m_start, m_hlt;
  int   m_run, m_match, m_win;

  function automatic void model_clear();
    m_first = 1'b1; m_last = 1'b0; m_run = 0;
    m_inwin = 1'b0; m_ref = 1'b0; m_match = 0; m_win = 0; m_wfail = 1'b0;
    m_rct = 1'b0; m_apt = 1'b0; m_start = 1'b0; m_hlt = 1'b0;
  endfunction

  function automatic exp_t model_sample(input logic b, input logic clr);
    exp_t e;
    e.b     = b;
    e.gated = m_hlt;
    if (clr) begin
      model_clear();
    end else begin
      if (m_first)          m_run = 1;
      else if (b != m_last) m_run = 1;
      else if (m_run < 32)  m_run = m_run + 1;
      m_first = 1'b0;
      m_last  = b;
      if (m_run == 32) m_rct = 1'b1;
      if (!m_inwin) begin
        m_inwin = 1'b1; m_ref = b; m_match = 1; m_win = 1; m_wfail = 1'b0;
      end else begin
        m_win = m_win + 1;
        if (b == m_ref) m_match = m_match + 1;
      end
      if (m_match == 600) begin m_apt = 1'b1; m_wfail = 1'b1; end
      if (m_win == 1024) begin
        m_inwin = 1'b0;
        if (!m_wfail) m_start = 1'b1;
      end
      m_hlt = m_start & ~m_rct & ~m_apt;
    end
    e.rct = m_rct;
    e.apt = m_apt;
    e.hlt = m_hlt;
    return e;
  endfunction

  // ---------------- scoreboard ----------------
  exp_t sb[$];
  int   bv_cnt = 0;
  int   bv_cyc = 0;
  int   rise_cyc = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.bitValid === 1'b1) begin
        bv_cnt++;
        bv_cyc = cyc;
        check("sample_pending_at_bitValid", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("bitOut", bus.bitOut, e.b);
          check("gatedValid", bus.gatedValid, e.gated);
          @(negedge clk);
          check("rctFail", bus.rctFail, e.rct);
          check("aptFail", bus.aptFail, e.apt);
          check("healthy", bus.healthy, e.hlt);
        end
      end
    end
  end

  // One clean four-phase sample; optionally assert clearFail on its bitValid cycle.
  task automatic send(input logic b, input int hi, input int lo, input logic clr);
    logic [15:0] w;
    logic        done;
    done = 1'b0;
    @(negedge clk);
    w    = 16'($urandom);
    w[0] = b;
    bus.CSCnt = w;
    sb.push_back(model_sample(b, clr));
    rise_cyc  = cyc;
    bus.CSReq = 1'b1;
    for (int k = 0; k < hi; k++) begin
      @(negedge clk);
      if (clr && !done && bus.bitValid === 1'b1) begin
        bus.clearFail = 1'b1;
        done = 1'b1;
        @(posedge clk);
        #1 bus.clearFail = 1'b0;
      end
    end
    if (clr) check("clear_aligned_with_bitValid", {31'd0, done}, 1);
    bus.CSReq = 1'b0;
    for (int k = 0; k < lo; k++) @(negedge clk);
    check("bitValid_arrived", sb.size(), 0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    bus.clearFail = 1'b1;
    @(negedge clk);
    bus.clearFail = 1'b0;
    model_clear();
    check("clear_rct", bus.rctFail, 0);
    check("clear_apt", bus.aptFail, 0);
    check("clear_healthy", bus.healthy, 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bitOut"}, bus.bitOut, 0);
    check({tag, "_bitValid"}, bus.bitValid, 0);
    check({tag, "_gatedValid"}, bus.gatedValid, 0);
    check({tag, "_rctFail"}, bus.rctFail, 0);
    check({tag, "_aptFail"}, bus.aptFail, 0);
    check({tag, "_healthy"}, bus.healthy, 0);
  endtask

  // One 1024-sample window: bit = (i mod 12) < thr, so runs never exceed 8.
  task automatic apt_window(input int thr, input logic exp_apt, input logic exp_hlt);
    int   ones;
    logic b;
    ones = 0;
    for (int i = 0; i < 1024; i++) begin
      b = ((i % 12) < thr);
      send(b, 4, 4, 1'b0);
      if (b) begin
        ones++;
        if (ones == 599) check("apt_at_599_matches", bus.aptFail, 0);
        if (ones == 600) check("apt_at_600_matches", bus.aptFail, 1);
      end
    end
    check("apt_window_end_aptFail", bus.aptFail, exp_apt);
    check("apt_window_end_healthy", bus.healthy, exp_hlt);
  endtask

  typedef struct {
    int   n;
    logic b;
    logic rct;
    logic hlt;
  } seg_t;

  seg_t segs[4];

  initial begin
    #1500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bv0, lat;
    logic b;

    segs[0] = '{n: 1,  b: 1'b0, rct: 1'b0, hlt: 1'b1};
    segs[1] = '{n: 31, b: 1'b1, rct: 1'b0, hlt: 1'b1};
    segs[2] = '{n: 1,  b: 1'b0, rct: 1'b0, hlt: 1'b1};
    segs[3] = '{n: 32, b: 1'b1, rct: 1'b1, hlt: 1'b0};

    rst = 1'b1;
    bus.CSReq = 1'b0;
    bus.CSCnt = '0;
    bus.clearFail = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;

    // Startup: 1024 alternating samples with 8/8 req pulses.
    for (int i = 0; i < 1024; i++) begin
      send(1'(i % 2), 8, 8, 1'b0);
      if (i == 0) begin
        lat = bv_cyc - rise_cyc;
        check("latency_3_to_4", {31'd0, (lat >= 3 && lat <= 4)}, 1);
      end
      if (i == 1022) check("healthy_before_1024", bus.healthy, 0);
    end
    check("startup_healthy", bus.healthy, 1);
    check("startup_rct", bus.rctFail, 0);
    check("startup_apt", bus.aptFail, 0);

    // RCT: 31 ones then a break is fine; 32 ones fails on the 32nd.
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < segs[s].n; k++) begin
        send(segs[s].b, 4, 4, 1'b0);
        if (s == 3 && k == 30) check("rct_after_31_ones", bus.rctFail, 0);
      end
      check($sformatf("seg%0d_rctFail", s), bus.rctFail, segs[s].rct);
      check($sformatf("seg%0d_healthy", s), bus.healthy, segs[s].hlt);
    end

    // clearFail on a bitValid cycle while rctFail is set; that bit is not counted.
    send(1'b1, 8, 4, 1'b1);
    check("clr_rct", bus.rctFail, 0);
    check("clr_apt", bus.aptFail, 0);
    check("clr_healthy", bus.healthy, 0);
    for (int k = 0; k < 31; k++) send(1'b0, 4, 4, 1'b0);
    check("post_clear_31_zeros", bus.rctFail, 0);
    send(1'b0, 4, 4, 1'b0);
    check("post_clear_32_zeros", bus.rctFail, 1);
    pulse_clear();

    // APT: 600 matches fail; after clear, 599 matches pass and start up.
    apt_window(8, 1'b1, 1'b0);
    pulse_clear();
    apt_window(7, 1'b0, 1'b1);

    // Long req: exactly one sample.
    bv0 = bv_cnt;
    send(1'b0, 100, 8, 1'b0);
    check("held_req_one_sample", bv_cnt - bv0, 1);

    // Req toggling asynchronously to clk (27 ns phases).
    bv0 = bv_cnt;
    #3;
    for (int k = 0; k < 20; k++) begin
      logic [15:0] w;
      b    = 1'($urandom);
      w    = 16'($urandom);
      w[0] = b;
      bus.CSCnt = w;
      sb.push_back(model_sample(b, 1'b0));
      bus.CSReq = 1'b1;
      #27;
      bus.CSReq = 1'b0;
      #27;
    end
    repeat (10) @(negedge clk);
    check("async_sample_count", bv_cnt - bv0, 20);
    check("async_all_drained", sb.size(), 0);
    if (sb.size() != 0) sb.delete();

    // Reset at sample 500 of a window; startup must begin again.
    while (!(m_inwin && m_win == 500)) send(1'(m_win % 2), 4, 4, 1'b0);
    check("pre_reset_healthy", bus.healthy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    model_clear();
    for (int i = 0; i < 1024; i++) begin
      send(1'(i % 2), 4, 4, 1'b0);
      if (i == 1022) check("rerun_healthy_before_1024", bus.healthy, 0);
    end
    check("rerun_healthy_after_1024", bus.healthy, 1);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
